// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode-stage control pipeline: opcodes,
// bundle widths, packed control bundles and their NOP values.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_t;

  localparam wb_t WB_NOP = '0;
  localparam m_t  M_NOP  = '0;
  localparam ex_t EX_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the WB/M/EX control bundles,
// an illegal-opcode flag and the jump indication.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EXT_ISA = 1'b1
) (
  input  logic [5:0] opcode,
  output wb_t        wb,
  output m_t         m,
  output ex_t        ex,
  output logic       illegal,
  output logic       jump
);

  // Opcode table; anything unsupported yields NOP bundles and illegal=1.
  always_comb begin
    wb      = WB_NOP;
    m       = M_NOP;
    ex      = EX_NOP;
    illegal = 1'b0;
    jump    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wb = wb_t'(2'b10);
        ex = ex_t'(4'b1100);
      end
      OP_LW: begin
        wb = wb_t'(2'b11);
        m  = m_t'(3'b010);
        ex = ex_t'(4'b0001);
      end
      OP_SW: begin
        m  = m_t'(3'b001);
        ex = ex_t'(4'b0001);
      end
      OP_BEQ: begin
        m  = m_t'(3'b100);
        ex = ex_t'(4'b0010);
      end
      OP_ADDI: begin
        if (EXT_ISA) begin
          wb = wb_t'(2'b10);
          ex = ex_t'(4'b0001);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J: begin
        if (EXT_ISA) begin
          jump = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Decode-stage control unit: decodes the opcode and carries the control
// bundles through the ID/EX, EX/MEM and MEM/WB stage registers, with
// stall/flush bubbles, sticky illegal detection and a bubble counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int EXT_ISA     = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       opcode,
  input  logic             stall,
  input  logic             flush,
  input  logic             err_clr,
  output logic             id_jump,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic             ex_valid,
  output logic [M_W-1:0]   mem_ctrl,
  output logic             mem_valid,
  output logic [WB_W-1:0]  wb_ctrl,
  output logic             wb_valid,
  output logic             err_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  wb_t  dec_wb;
  m_t   dec_m;
  ex_t  dec_ex;
  logic dec_illegal;
  logic dec_jump;

  wb_t  idex_wb;
  m_t   idex_m;
  ex_t  idex_ex;
  logic idex_valid;

  wb_t  exmem_wb;
  m_t   exmem_m;
  logic exmem_valid;

  wb_t  memwb_wb;
  logic memwb_valid;

  logic bubble;
  logic kill_exmem;
  logic err_set;

  ctrl_decode #(
    .EXT_ISA (EXT_ISA != 0)
  ) u_decode (
    .opcode  (opcode),
    .wb      (dec_wb),
    .m       (dec_m),
    .ex      (dec_ex),
    .illegal (dec_illegal),
    .jump    (dec_jump)
  );

  assign bubble     = flush | stall;
  assign kill_exmem = flush && (FLUSH_DEPTH >= 2);
  assign err_set    = id_valid & ~flush & ~stall & dec_illegal;
  assign id_jump    = id_valid & dec_jump;

  // ID/EX: flush, stall or an empty slot all load a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_wb    <= WB_NOP;
      idex_m     <= M_NOP;
      idex_ex    <= EX_NOP;
      idex_valid <= 1'b0;
    end else if (bubble || !id_valid) begin
      idex_wb    <= WB_NOP;
      idex_m     <= M_NOP;
      idex_ex    <= EX_NOP;
      idex_valid <= 1'b0;
    end else begin
      // Illegal opcodes already decode to NOP bundles; only valid drops.
      idex_wb    <= dec_wb;
      idex_m     <= dec_m;
      idex_ex    <= dec_ex;
      idex_valid <= ~dec_illegal;
    end
  end

  // EX/MEM: follows ID/EX, killed by flush only in the deep-flush build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_wb    <= WB_NOP;
      exmem_m     <= M_NOP;
      exmem_valid <= 1'b0;
    end else if (kill_exmem) begin
      exmem_wb    <= WB_NOP;
      exmem_m     <= M_NOP;
      exmem_valid <= 1'b0;
    end else begin
      exmem_wb    <= idex_wb;
      exmem_m     <= idex_m;
      exmem_valid <= idex_valid;
    end
  end

  // MEM/WB: plain follower of EX/MEM, never flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_wb    <= WB_NOP;
      memwb_valid <= 1'b0;
    end else begin
      memwb_wb    <= exmem_wb;
      memwb_valid <= exmem_valid;
    end
  end

  // Saturating count of edges that inserted a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // Sticky illegal flag; a new set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (err_set) begin
      err_illegal <= 1'b1;
    end else if (err_clr) begin
      err_illegal <= 1'b0;
    end
  end

  assign ex_ctrl   = idex_ex;
  assign ex_valid  = idex_valid;
  assign mem_ctrl  = exmem_m;
  assign mem_valid = exmem_valid;
  assign wb_ctrl   = memwb_wb;
  assign wb_valid  = memwb_valid;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances share the stimulus -- A uses
// EXT_ISA=1/FLUSH_DEPTH=1/CNT_W=16, B uses EXT_ISA=0/FLUSH_DEPTH=2/CNT_W=3.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       err_clr = 1'b0;

  logic        a_id_jump, a_ex_valid, a_mem_valid, a_wb_valid, a_err;
  logic [3:0]  a_ex_ctrl;
  logic [2:0]  a_mem_ctrl;
  logic [1:0]  a_wb_ctrl;
  logic [15:0] a_cnt;

  logic        b_id_jump, b_ex_valid, b_mem_valid, b_wb_valid, b_err;
  logic [3:0]  b_ex_ctrl;
  logic [2:0]  b_mem_ctrl;
  logic [1:0]  b_wb_ctrl;
  logic [2:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_pipe #(.EXT_ISA(1), .FLUSH_DEPTH(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .id_jump(a_id_jump), .ex_ctrl(a_ex_ctrl), .ex_valid(a_ex_valid),
    .mem_ctrl(a_mem_ctrl), .mem_valid(a_mem_valid), .wb_ctrl(a_wb_ctrl),
    .wb_valid(a_wb_valid), .err_illegal(a_err), .bubble_cnt(a_cnt)
  );

  ctrl_pipe #(.EXT_ISA(0), .FLUSH_DEPTH(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .id_jump(b_id_jump), .ex_ctrl(b_ex_ctrl), .ex_valid(b_ex_valid),
    .mem_ctrl(b_mem_ctrl), .mem_valid(b_mem_valid), .wb_ctrl(b_wb_ctrl),
    .wb_valid(b_wb_valid), .err_illegal(b_err), .bubble_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  logic [13:0] obs0, obs1;
  logic [15:0] cnt0, cnt1;
  assign obs0 = {a_id_jump, a_ex_ctrl, a_ex_valid, a_mem_ctrl, a_mem_valid, a_wb_ctrl, a_wb_valid, a_err};
  assign obs1 = {b_id_jump, b_ex_ctrl, b_ex_valid, b_mem_ctrl, b_mem_valid, b_wb_ctrl, b_wb_valid, b_err};
  assign cnt0 = a_cnt;
  assign cnt1 = {13'b0, b_cnt};

  // Reference model: per instance, the in-flight instruction in each of the
  // three stages ({wb,m,ex} bundle plus liveness), sticky error and count.
  int ext  [2] = '{1, 0};
  int fd   [2] = '{1, 2};
  int cmax [2] = '{65535, 7};
  logic [8:0] bd [2][3];
  bit         v  [2][3];
  bit         merr [2];
  int         mcnt [2];

  function automatic void ref_decode(input int e, input logic [5:0] op,
                                     output logic [8:0] b, output bit ill);
    b = '0;
    ill = 1'b0;
    case (op)
      6'b000000: b = 9'b10_000_1100;
      6'b100011: b = 9'b11_010_0001;
      6'b101011: b = 9'b00_001_0001;
      6'b000100: b = 9'b00_100_0010;
      6'b001000: if (e != 0) b = 9'b10_000_0001; else ill = 1'b1;
      6'b000010: if (e == 0) ill = 1'b1;
      default:   ill = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) begin
        bd[k][s] = '0;
        v[k][s] = 1'b0;
      end
      merr[k] = 1'b0;
      mcnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [8:0] b;
    bit ill;
    for (int k = 0; k < 2; k++) begin
      ref_decode(ext[k], opcode, b, ill);
      bd[k][2] = bd[k][1];
      v[k][2] = v[k][1];
      if (flush && fd[k] == 2) begin
        bd[k][1] = '0;
        v[k][1] = 1'b0;
      end else begin
        bd[k][1] = bd[k][0];
        v[k][1] = v[k][0];
      end
      if (flush || stall || !id_valid) begin
        bd[k][0] = '0;
        v[k][0] = 1'b0;
      end else begin
        bd[k][0] = b;
        v[k][0] = !ill;
      end
      if (id_valid && !flush && !stall && ill) merr[k] = 1'b1;
      else if (err_clr) merr[k] = 1'b0;
      if ((flush || stall) && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
    end
  endtask

  function automatic logic [13:0] exp_obs(int k);
    logic jmp;
    jmp = id_valid && (ext[k] != 0) && (opcode == 6'b000010);
    return {jmp,
            v[k][0] ? bd[k][0][3:0] : 4'b0, v[k][0],
            v[k][1] ? bd[k][1][6:4] : 3'b0, v[k][1],
            v[k][2] ? bd[k][2][8:7] : 2'b0, v[k][2],
            merr[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0; opcode = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs0 !== 14'b0 || cnt0 !== 16'd0) begin
      errors++; $display("FAIL reset_a got=%b/%0d exp=0/0", obs0, cnt0);
    end
    checks++;
    if (obs1 !== 14'b0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL reset_b got=%b/%0d exp=0/0", obs1, cnt1);
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [5:0] ops [4] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100};
    logic [3:0] exs [4] = '{4'b1100, 4'b0001, 4'b0001, 4'b0010};
    logic [2:0] ms  [4] = '{3'b000, 3'b010, 3'b001, 3'b100};
    logic [1:0] wbs [4] = '{2'b10, 2'b11, 2'b00, 2'b00};
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      if (e <= 4) begin id_valid = 1'b1; opcode = ops[e-1]; end
      else begin id_valid = 1'b0; opcode = '0; end
      tick();
      if (e <= 4) begin
        checks++;
        if (a_ex_ctrl !== exs[e-1] || a_ex_valid !== 1'b1) begin
          errors++; $display("FAIL stream_ex e=%0d got=%b/%b exp=%b/1", e, a_ex_ctrl, a_ex_valid, exs[e-1]);
        end
      end
      if (e >= 2 && e <= 5) begin
        checks++;
        if (a_mem_ctrl !== ms[e-2] || a_mem_valid !== 1'b1) begin
          errors++; $display("FAIL stream_mem e=%0d got=%b/%b exp=%b/1", e, a_mem_ctrl, a_mem_valid, ms[e-2]);
        end
      end
      if (e >= 3) begin
        checks++;
        if (a_wb_ctrl !== wbs[e-3] || a_wb_valid !== 1'b1) begin
          errors++; $display("FAIL stream_wb e=%0d got=%b/%b exp=%b/1", e, a_wb_ctrl, a_wb_valid, wbs[e-3]);
        end
      end
    end
    checks++;
    if (a_cnt !== 16'd0 || b_cnt !== 3'd0) begin
      errors++; $display("FAIL stream_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    id_valid = 1'b1; opcode = 6'b100011;
    tick();
    checks++;
    if (a_ex_ctrl !== 4'b0001 || a_ex_valid !== 1'b1) begin
      errors++; $display("FAIL stall_lw got=%b/%b exp=0001/1", a_ex_ctrl, a_ex_valid);
    end
    opcode = 6'b000000; stall = 1'b1;
    tick();
    checks++;
    if (a_ex_ctrl !== 4'b0000 || a_ex_valid !== 1'b0) begin
      errors++; $display("FAIL stall_bubble got=%b/%b exp=0000/0", a_ex_ctrl, a_ex_valid);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (a_ex_ctrl !== 4'b1100 || a_ex_valid !== 1'b1) begin
      errors++; $display("FAIL stall_resume got=%b/%b exp=1100/1", a_ex_ctrl, a_ex_valid);
    end
    checks++;
    if (a_cnt !== 16'd1 || b_cnt !== 3'd1) begin
      errors++; $display("FAIL stall_cnt got=%0d/%0d exp=1/1", a_cnt, b_cnt);
    end
    id_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    id_valid = 1'b1; opcode = 6'b000100;
    tick();
    opcode = 6'b000000;
    tick();
    opcode = 6'b100011; flush = 1'b1;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    checks++;
    if (a_ex_valid !== 1'b0 || a_ex_ctrl !== 4'b0 || a_mem_valid !== 1'b1 || a_mem_ctrl !== 3'b000) begin
      errors++; $display("FAIL flush_d1 got=ex%b/%b mem%b/%b exp=ex0000/0 mem000/1", a_ex_ctrl, a_ex_valid, a_mem_ctrl, a_mem_valid);
    end
    checks++;
    if (b_ex_valid !== 1'b0 || b_ex_ctrl !== 4'b0 || b_mem_valid !== 1'b0 || b_mem_ctrl !== 3'b000) begin
      errors++; $display("FAIL flush_d2 got=ex%b/%b mem%b/%b exp=ex0000/0 mem000/0", b_ex_ctrl, b_ex_valid, b_mem_ctrl, b_mem_valid);
    end
    checks++;
    if (a_wb_valid !== 1'b1 || b_wb_valid !== 1'b1 || a_wb_ctrl !== 2'b00 || b_wb_ctrl !== 2'b00) begin
      errors++; $display("FAIL flush_memwb got=%b%b/%b%b exp=1 1/00 00", a_wb_valid, b_wb_valid, a_wb_ctrl, b_wb_ctrl);
    end
    tick();
    checks++;
    if (a_wb_valid !== 1'b1 || a_wb_ctrl !== 2'b10 || b_wb_valid !== 1'b0 || b_wb_ctrl !== 2'b00) begin
      errors++; $display("FAIL flush_after got=%b/%b %b/%b exp=10/1 00/0", a_wb_ctrl, a_wb_valid, b_wb_ctrl, b_wb_valid);
    end
  endtask

  task automatic test_ext_isa();
    do_reset();
    id_valid = 1'b1; opcode = 6'b001000;
    tick();
    checks++;
    if (a_ex_ctrl !== 4'b0001 || a_ex_valid !== 1'b1 || a_err !== 1'b0) begin
      errors++; $display("FAIL addi_ext got=%b/%b/%b exp=0001/1/0", a_ex_ctrl, a_ex_valid, a_err);
    end
    checks++;
    if (b_ex_ctrl !== 4'b0000 || b_ex_valid !== 1'b0 || b_err !== 1'b1) begin
      errors++; $display("FAIL addi_base got=%b/%b/%b exp=0000/0/1", b_ex_ctrl, b_ex_valid, b_err);
    end
    id_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (a_wb_ctrl !== 2'b10 || a_wb_valid !== 1'b1 || b_wb_valid !== 1'b0) begin
      errors++; $display("FAIL addi_wb got=%b/%b/%b exp=10/1/0", a_wb_ctrl, a_wb_valid, b_wb_valid);
    end
    id_valid = 1'b1; opcode = 6'b111111; err_clr = 1'b1;
    tick();
    checks++;
    if (a_err !== 1'b1 || b_err !== 1'b1) begin
      errors++; $display("FAIL err_set_wins got=%b/%b exp=1/1", a_err, b_err);
    end
    id_valid = 1'b0;
    tick();
    err_clr = 1'b0;
    checks++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      errors++; $display("FAIL err_clr got=%b/%b exp=0/0", a_err, b_err);
    end
    id_valid = 1'b1; opcode = 6'b000010;
    #1;
    checks++;
    if (a_id_jump !== 1'b1 || b_id_jump !== 1'b0) begin
      errors++; $display("FAIL id_jump got=%b/%b exp=1/0", a_id_jump, b_id_jump);
    end
    tick();
    id_valid = 1'b0;
    checks++;
    if (a_ex_valid !== 1'b1 || a_ex_ctrl !== 4'b0000 || a_err !== 1'b0 || b_err !== 1'b1) begin
      errors++; $display("FAIL j_decode got=%b/%b/%b/%b exp=1/0000/0/1", a_ex_valid, a_ex_ctrl, a_err, b_err);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    id_valid = 1'b1; opcode = 6'b000000; stall = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (b_cnt !== 3'((i < 7) ? i : 7) || a_cnt !== 16'(i)) begin
        errors++; $display("FAIL saturate i=%0d got=%0d/%0d exp=%0d/%0d", i, a_cnt, b_cnt, i, (i < 7) ? i : 7);
      end
    end
    stall = 1'b0; id_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    int idx;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      idx = $urandom_range(0, 7);
      opcode = (idx < 6) ? ops[idx] : 6'($urandom);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (obs0 !== exp_obs(0) || obs1 !== exp_obs(1)) begin
        errors++; $display("FAIL rand_pre n=%0d got=%b/%b exp=%b/%b", n, obs0, obs1, exp_obs(0), exp_obs(1));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (((k == 0) ? obs0 : obs1) !== exp_obs(k) || ((k == 0) ? cnt0 : cnt1) !== 16'(mcnt[k])) begin
          errors++;
          $display("FAIL rand_post n=%0d k=%0d got=%b/%0d exp=%b/%0d", n, k, (k == 0) ? obs0 : obs1,
                   (k == 0) ? cnt0 : cnt1, exp_obs(k), mcnt[k]);
        end
      end
    end
    stall = 1'b0; flush = 1'b0; err_clr = 1'b0; id_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    id_valid = 1'b1; opcode = 6'b100011;
    tick(); tick();
    opcode = 6'b111111; stall = 1'b1;
    tick();
    opcode = 6'b111111; stall = 1'b0;
    tick();
    id_valid = 1'b0; opcode = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 14'b0 || cnt0 !== 16'd0 || obs1 !== 14'b0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL async_reset got=%b/%0d %b/%0d exp=0/0", obs0, cnt0, obs1, cnt1);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_ext_isa();
    test_saturate();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
